// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   - FSM state encoding (localparams plus a typed enum built on them)
//   - control codes for the shared add/subtract stage
package seq_div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } div_state_e;

  localparam logic CTR_ADD = 1'b0;
  localparam logic CTR_SUB = 1'b1;

endpackage

// File: rtl/add_sub_stage.sv
// Combinational add/subtract stage.
//   a, b   : W-bit operands
//   CTR    : 0 -> a + b, 1 -> a + ~b + 1 (a - b)
//   sum    : W-bit result
//   carry  : carry-out; in subtract mode 1 means no borrow (a >= b)
module add_sub_stage #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         CTR,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W-1:0] b_eff;
  logic [W:0]   full;

  always_comb begin
    b_eff = CTR ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, CTR};
  end

  assign sum   = full[W-1:0];
  assign carry = full[W];

endmodule

// File: rtl/seq_div_restoring.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, honoured only while idle
//   dividend     : unsigned dividend, captured on accepted start
//   divisor      : unsigned divisor, captured on accepted start
//   busy         : high while an operation is in flight (RUN or DONE)
//   done         : one-cycle pulse, results valid from this cycle
//   quotient     : result, held until the next accepted start
//   remainder    : result, held until the next accepted start
//   div_by_zero  : flags a zero divisor, held like the results
module seq_div_restoring
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   r_q;     // one extra bit so the trial subtract never overflows
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             no_borrow;

  // Shift the next dividend bit into the partial remainder.
  assign trial = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  add_sub_stage #(
    .W (WIDTH + 1)
  ) u_stage (
    .a     (trial),
    .b     ({1'b0, dvs_q}),
    .CTR   (CTR_SUB),
    .sum   (diff),
    .carry (no_borrow)
  );

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      dvs_q       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (divisor != '0) begin
              dvs_q       <= divisor;
              q_q         <= dividend;
              r_q         <= '0;
              cnt_q       <= CntW'(WIDTH);
              div_by_zero <= 1'b0;
              state_q     <= StRun;
            end else begin
              // Skip the iteration; DONE copies these through unchanged.
              q_q         <= '1;
              r_q         <= {1'b0, dividend};
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StRun: begin
          q_q   <= {q_q[WIDTH-2:0], no_borrow};
          r_q   <= no_borrow ? diff : trial;  // restore on borrow
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          done      <= 1'b1;
          quotient  <= q_q;
          remainder <= r_q[WIDTH-1:0];
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_restoring.sv
module tb_seq_div_restoring;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_div_restoring #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int n;
    int d;
    int q;
    int r;
    int dz;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_due = 0;
  bit   prev_done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all-ones / dividend.
  function automatic exp_t model(input int n, input int d, input int due);
    exp_t e;
    e.n   = n;
    e.d   = d;
    e.dz  = (d == 0);
    e.q   = (d == 0) ? (1 << W) - 1 : n / d;
    e.r   = (d == 0) ? n : n % d;
    e.due = due;
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (prev_done) check("done_pulse_width", 2, 1);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", cyc, e.due);
        check("quotient", int'(quotient), e.q);
        check("remainder", int'(remainder), e.r);
        check("div_by_zero", int'(div_by_zero), e.dz);
        if (e.d != 0) begin
          check("identity", int'(quotient) * e.d + int'(remainder), e.n);
          check("rem_lt_div", int'(int'(remainder) < e.d), 1);
        end
      end
    end
    prev_done = done;
  end

  // Drive start for one edge (called at a negedge while the DUT is idle).
  task automatic issue(input int n, input int d, input bit expect_result);
    int lat;
    int due;
    lat      = (d == 0) ? 1 : W + 1;
    due      = cyc + 1 + lat;
    start    = 1'b1;
    dividend = W'(n);
    divisor  = W'(d);
    @(posedge clk);
    if (expect_result) begin
      sb.push_back(model(n, d, due));
      last_due = due;
    end
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_due();
    while (cyc < last_due) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    issue(13, 3, 1'b1); wait_due();
    issue(15, 1, 1'b1); wait_due();
    issue(2, 7, 1'b1);  wait_due();
    issue(0, 5, 1'b1);  wait_due();
    issue(9, 0, 1'b1);  wait_due();

    // Start while busy is ignored; results then hold.
    issue(13, 3, 1'b1);
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_due();
    repeat (3) begin
      @(negedge clk);
      check("hold_quotient", int'(quotient), 4);
      check("hold_remainder", int'(remainder), 1);
      check("hold_busy", int'(busy), 0);
    end

    // Reset mid-run abandons the operation.
    issue(7, 2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    check("midrst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(12, 5, 1'b1); wait_due();

    // Exhaustive, back-to-back.
    for (int n = 0; n < (1 << W); n++) begin
      for (int d = 0; d < (1 << W); d++) begin
        issue(n, d, 1'b1);
        wait_due();
      end
    end

    // Random operands with random idle gaps.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)), 1'b1);
      wait_due();
    end

    // Drain with a bound.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("drain_pending", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
